// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer:
// tile codes, sequencer states, undo history entry layout and winning lines.
package game_pkg;

    localparam int NUM_TILES = 9;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] TILE_EMPTY = 2'b00;
    localparam logic [1:0] TILE_X     = 2'b01;
    localparam logic [1:0] TILE_O     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_CHECK,
        S_UNDO,
        S_OVER
    } state_t;

    typedef struct packed {
        logic [17:0] tiles;
        logic        turn;
    } hist_entry_t;

    // Rows, columns, then the two diagonals, as row-major tile indices.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [1:0] tile_at(input logic [17:0] board, input int idx);
        return board[2*idx +: 2];
    endfunction

endpackage

// File: rtl/win_checker.sv
// Combinational board evaluation: reports a completed line for either
// player and whether every tile is occupied.
module win_checker
    import game_pkg::*;
(
    input  logic [17:0] tiles,
    output logic        win_x,
    output logic        win_o,
    output logic        full
);

    always_comb begin
        // NOTE: every output gets a default before any conditional write so no latch is inferred.
        win_x = 1'b0;
        win_o = 1'b0;
        full  = 1'b1;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (tile_at(tiles, WIN_LINES[l][0]) != TILE_EMPTY &&
                tile_at(tiles, WIN_LINES[l][0]) == tile_at(tiles, WIN_LINES[l][1]) &&
                tile_at(tiles, WIN_LINES[l][1]) == tile_at(tiles, WIN_LINES[l][2])) begin
                if (tile_at(tiles, WIN_LINES[l][0]) == TILE_X) win_x = 1'b1;
                else                                          win_o = 1'b1;
            end
        end
        for (int i = 0; i < NUM_TILES; i++) begin
            if (tile_at(tiles, i) == TILE_EMPTY) full = 1'b0;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Owns the board and turn; conditions raw switch/undo inputs, validates and
// commits moves, keeps a circular undo history and detects win or draw.
module move_sequencer
    import game_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  input_switches,
    input  logic        undo_sig,
    output logic [17:0] tiles,
    output logic        current_turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_count,
    output logic        busy,
    output logic        move_reject
);

    logic [8:0]  sw_meta, sw_sync, sw_prev, sw_rise;
    logic        undo_meta, undo_sync, undo_prev, undo_rise;
    logic        rise_any;
    logic [3:0]  rise_idx;

    state_t      state, next_state;
    logic [3:0]  sel_idx, next_sel_idx;
    logic [17:0] next_tiles;
    logic        next_turn, next_game_over, next_reject;
    logic [1:0]  next_winner;
    logic [3:0]  next_count;

    logic        win_x, win_o, full;

    hist_entry_t            hist_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr, hist_count;
    logic                   hist_push, hist_pop;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_prev   <= '0;
            undo_meta <= 1'b0;
            undo_sync <= 1'b0;
            undo_prev <= 1'b0;
        end else begin
            sw_meta   <= input_switches;
            sw_sync   <= sw_meta;
            sw_prev   <= sw_sync;
            undo_meta <= undo_sig;
            undo_sync <= undo_meta;
            undo_prev <= undo_sync;
        end
    end

    assign sw_rise   = sw_sync & ~sw_prev;
    assign undo_rise = undo_sync & ~undo_prev;
    assign rise_any  = |sw_rise;

    // Lowest rising index wins; simultaneous higher rises are dropped.
    always_comb begin
        rise_idx = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (sw_rise[i]) rise_idx = 4'(i);
        end
    end

    win_checker u_win_checker (
        .tiles (tiles),
        .win_x (win_x),
        .win_o (win_o),
        .full  (full)
    );

    assign rd_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
    assign busy   = (state != S_IDLE) && (state != S_OVER);

    always_comb begin
        next_state     = state;
        next_sel_idx   = sel_idx;
        next_tiles     = tiles;
        next_turn      = current_turn;
        next_count     = move_count;
        next_game_over = game_over;
        next_winner    = winner;
        next_reject    = 1'b0;
        hist_push      = 1'b0;
        hist_pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (undo_rise) begin
                    next_state = S_UNDO;
                end else if (rise_any) begin
                    next_sel_idx = rise_idx;
                    if (tile_at(tiles, int'(rise_idx)) == TILE_EMPTY) next_state  = S_MOVE;
                    else                                              next_reject = 1'b1;
                end
            end
            S_MOVE: begin
                hist_push = 1'b1;
                for (int i = 0; i < NUM_TILES; i++) begin
                    if (sel_idx == 4'(i)) next_tiles[2*i +: 2] = current_turn ? TILE_O : TILE_X;
                end
                next_turn  = ~current_turn;
                next_count = move_count + 4'd1;
                next_state = S_CHECK;
            end
            S_CHECK: begin
                if (win_x || win_o) begin
                    next_winner    = win_x ? TILE_X : TILE_O;
                    next_game_over = 1'b1;
                    next_state     = S_OVER;
                end else if (full || move_count == 4'd9) begin
                    next_winner    = TILE_EMPTY;
                    next_game_over = 1'b1;
                    next_state     = S_OVER;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_UNDO: begin
                if (hist_count != '0) begin
                    hist_pop       = 1'b1;
                    next_tiles     = hist_mem[rd_ptr].tiles;
                    next_turn      = hist_mem[rd_ptr].turn;
                    next_count     = move_count - 4'd1;
                    next_game_over = 1'b0;
                    next_winner    = TILE_EMPTY;
                end else begin
                    next_reject = 1'b1;
                end
                next_state = S_IDLE;
            end
            S_OVER: begin
                if (undo_rise) next_state = S_UNDO;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            sel_idx      <= '0;
            tiles        <= '0;
            current_turn <= 1'b0;
            move_count   <= '0;
            game_over    <= 1'b0;
            winner       <= TILE_EMPTY;
            move_reject  <= 1'b0;
        end else begin
            state        <= next_state;
            sel_idx      <= next_sel_idx;
            tiles        <= next_tiles;
            current_turn <= next_turn;
            move_count   <= next_count;
            game_over    <= next_game_over;
            winner       <= next_winner;
            move_reject  <= next_reject;
        end
    end

    // Circular history: a push at full depth overwrites the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            hist_count <= '0;
        end else if (hist_push) begin
            wr_ptr     <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            hist_count <= (hist_count == PTR_W'(DEPTH)) ? hist_count : hist_count + 1'b1;
        end else if (hist_pop) begin
            wr_ptr     <= rd_ptr;
            hist_count <= hist_count - 1'b1;
        end
    end

    // NOTE: the history storage has no reset; hist_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (hist_push) hist_mem[wr_ptr] <= '{tiles: tiles, turn: current_turn};
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed game scenarios plus random
// move/undo traffic compared against a board-level reference model.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  input_switches;
    logic        undo_sig;
    logic [17:0] tiles;
    logic        current_turn;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  move_count;
    logic        busy;
    logic        move_reject;

    move_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .input_switches (input_switches),
        .undo_sig       (undo_sig),
        .tiles          (tiles),
        .current_turn   (current_turn),
        .game_over      (game_over),
        .winner         (winner),
        .move_count     (move_count),
        .busy           (busy),
        .move_reject    (move_reject)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rej_seen = 0;
    int rej_expected = 0;

    always @(negedge clk) if (move_reject === 1'b1) rej_seen++;

    // Reference model: board as 0 empty / 1 X / 2 O, history as snapshot queues.
    int          m_board [9];
    int          m_turn, m_count, m_over, m_winner;
    logic [17:0] h_board [$];
    int          h_turn  [$];
    int          lines [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [17:0] model_tiles();
        logic [17:0] v = '0;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(m_board[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_turn = 0; m_count = 0; m_over = 0; m_winner = 0;
        h_board.delete();
        h_turn.delete();
    endtask

    task automatic model_place(input int idx);
        h_board.push_back(model_tiles());
        h_turn.push_back(m_turn);
        m_board[idx] = (m_turn == 0) ? 1 : 2;
        m_turn  = 1 - m_turn;
        m_count = m_count + 1;
        for (int l = 0; l < 8; l++) begin
            if (m_board[lines[l][0]] != 0 &&
                m_board[lines[l][0]] == m_board[lines[l][1]] &&
                m_board[lines[l][1]] == m_board[lines[l][2]]) begin
                m_over = 1;
                m_winner = m_board[lines[l][0]];
            end
        end
        if (!m_over && m_count == 9) begin
            m_over = 1;
            m_winner = 0;
        end
    endtask

    task automatic model_undo();
        logic [17:0] snap;
        snap = h_board.pop_back();
        for (int i = 0; i < 9; i++) m_board[i] = int'(snap[2*i +: 2]);
        m_turn   = h_turn.pop_back();
        m_count  = m_count - 1;
        m_over   = 0;
        m_winner = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " tiles"},   32'(tiles),        32'(model_tiles()));
        check({tag, " turn"},    32'(current_turn), 32'(m_turn));
        check({tag, " count"},   32'(move_count),   32'(m_count));
        check({tag, " over"},    32'(game_over),    32'(m_over));
        check({tag, " winner"},  32'(winner),       32'(m_winner));
        check({tag, " busy"},    32'(busy),         32'd0);
        check({tag, " rejects"}, 32'(rej_seen),     32'(rej_expected));
    endtask

    // One move/undo event: model first, then drive and check the pipeline timing.
    task automatic step(input logic [8:0] sw, input logic un, input string tag);
        logic [17:0] prior;
        int          active;
        int          idx;
        prior  = model_tiles();
        active = 0;
        if (un) begin
            active = 1;
            if (h_board.size() == 0) rej_expected++;
            else model_undo();
        end else if (sw != 0 && !m_over) begin
            idx = 0;
            while (!sw[idx]) idx++;
            if (m_board[idx] != 0) rej_expected++;
            else begin
                active = 1;
                model_place(idx);
            end
        end
        @(negedge clk);
        input_switches = sw;
        undo_sig = un;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " busy@t+2"},  32'(busy),  32'(active));
        check({tag, " tiles@t+2"}, 32'(tiles), 32'(prior));
        @(posedge clk);
        #1;
        check({tag, " tiles@t+3"}, 32'(tiles), 32'(model_tiles()));
        @(posedge clk);
        #1;
        check({tag, " over@t+4"}, 32'(game_over), 32'(m_over));
        repeat (4) @(negedge clk);
        input_switches = '0;
        undo_sig = 1'b0;
        repeat (5) @(negedge clk);
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        input_switches = '0;
        undo_sig = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int win_seq  [5] = '{0, 3, 1, 4, 2};
        int kind;
        logic [8:0] mask;

        reset = 1'b1;
        input_switches = '0;
        undo_sig = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        step(9'h010, 1'b0, "x_on_4");
        check("first_move_board", 32'(tiles), 32'h00100);
        step(9'h010, 1'b0, "occupied_4");
        step(9'h001, 1'b0, "o_on_0");
        step(9'h000, 1'b1, "undo_1");
        check("undo_1_board", 32'(tiles), 32'h00100);
        step(9'h000, 1'b1, "undo_2");
        step(9'h000, 1'b1, "undo_empty");

        foreach (win_seq[k]) step(9'(1 << win_seq[k]), 1'b0, "win_row");
        check("x_winner", 32'(winner), 32'h1);
        step(9'h100, 1'b0, "over_ignore_8");
        step(9'h000, 1'b1, "undo_from_over");
        step(9'h020, 1'b1, "undo_beats_sw5");

        apply_reset();
        check_all("reset_2");
        foreach (draw_seq[k]) step(9'(1 << draw_seq[k]), 1'b0, "draw");
        check("draw_count", 32'(move_count), 32'd9);

        apply_reset();
        step(9'h001, 1'b0, "pre_reset_move");
        @(negedge clk);
        input_switches = 9'h002;
        repeat (3) @(posedge clk);
        #1;
        check("in_move_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        input_switches = '0;
        #1;
        check("async_tiles", 32'(tiles), 32'd0);
        check("async_turn",  32'(current_turn), 32'd0);
        check("async_count", 32'(move_count), 32'd0);
        check("async_over",  32'({game_over, winner, busy, move_reject}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("after_async_reset");

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            mask = (kind < 5) ? 9'(1 << $urandom_range(0, 8)) : 9'($urandom_range(1, 511));
            if (kind == 9)      step(mask, 1'b1, "rand_both");
            else if (kind >= 7) step(9'h000, 1'b1, "rand_undo");
            else                step(mask, 1'b0, "rand_move");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Owns the tic-tac-toe board register and the turn bit; sequences every move and undo.
- Receives raw switch and undo inputs, synchronises and edge-detects them, and validates moves against the board.
- Commits a valid move, keeps a bounded undo history, and evaluates win or draw after each commit.
- Drives the board vector consumed by the game-play and tile-display blocks.

Parameters:
- DEPTH, 9: undo history entries (1..9); each entry holds board[17:0] plus turn.
- PTR_W, 4: history pointer/count width; must satisfy 2**PTR_W > DEPTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- input_switches  in  9  raw tile-select switches; bit i selects tile i (row-major, tile 0 top-left)
- undo_sig  in  1  raw undo request, level
- tiles  out  18  board; tiles[2*i+:2] is tile i: 00 empty, 01 X, 10 O (11 never produced)
- current_turn  out  1  0 = X to move, 1 = O to move
- game_over  out  1  high in S_OVER
- winner  out  2  00 none/draw, 01 X, 10 O; valid while game_over
- move_count  out  4  moves currently on board, 0..9
- busy  out  1  high in any state other than S_IDLE and S_OVER
- move_reject  out  1  one-cycle pulse: move selected an occupied tile, or undo requested with empty history

Behaviour:
- Reset (async, active-high) values:
  - tiles = 0, current_turn = 0, game_over = 0, winner = 00, move_count = 0, busy = 0, move_reject = 0.
  - History count = 0, state = S_IDLE.
  - Synchroniser and edge flops = 0.
- Input conditioning:
  - input_switches and undo_sig each pass through a 2-flop synchroniser, then a previous-value register.
  - rise = sync & ~prev.
- Move selection: lowest index i with rise[i]. Other rising bits in the same cycle are discarded, not queued.
- S_IDLE:
  - undo rise takes priority over any switch rise in the same cycle -> S_UNDO.
  - Else if any switch rise: latch index into sel_idx.
    - Tile empty -> S_MOVE.
    - Tile occupied -> pulse move_reject, stay in S_IDLE.
- S_MOVE (1 cycle):
  - Push {tiles, current_turn} to history.
  - Write tile sel_idx with 01 if current_turn = 0, else 10.
  - Toggle current_turn; move_count += 1.
  - Next state: S_CHECK.
- S_CHECK (1 cycle): win_checker evaluates the registered board.
  - Line found -> winner = owner of the line, game_over = 1, go to S_OVER.
  - Else move_count == 9 -> winner = 00, game_over = 1, go to S_OVER.
  - Else -> S_IDLE.
- S_UNDO (1 cycle):
  - History count > 0: pop and restore tiles and current_turn; move_count -= 1; clear game_over and winner.
  - History empty: pulse move_reject, change nothing.
  - Next state: S_IDLE.
- S_OVER: switch rises are ignored with no reject pulse. Undo rise -> S_UNDO.
- Latency, for input_switches[i] first sampled high at edge t:
  - rise is visible after edge t+1.
  - State moves to S_MOVE at edge t+2.
  - tiles updates at edge t+3.
  - game_over asserts at edge t+4 if the move ends the game.
- History is circular with wrap-around. Push when count == DEPTH overwrites the oldest entry and count saturates at DEPTH. With DEPTH = 9 this never triggers.
- Events arriving while busy are lost; a new rise edge is required.
- Reset asserted mid-sequence returns everything to reset values immediately. There is no partial commit.

Decomposition:
- Package game_pkg:
  - Tile codes: TILE_EMPTY = 2'b00, TILE_X = 2'b01, TILE_O = 2'b10.
  - State enum: S_IDLE, S_MOVE, S_CHECK, S_UNDO, S_OVER.
  - The 8 winning lines as tile-index triples.
- Sub-module win_checker (combinational):
  - Inputs: tiles[17:0].
  - Outputs: win_x, win_o, full.

Test Plan:
- Reset, then pulse input_switches[4] -> tiles = 18'h00100 at edge t+3, current_turn = 1, move_count = 1, move_reject never pulses.
- X plays tiles 0, 1, 2 with O on 3 and 4 in between -> game_over = 1 and winner = 01 at edge t+4 after the 5th move. A following switch rise on tile 8 leaves tiles unchanged.
- Move onto occupied tile 4 -> move_reject pulses for exactly 1 cycle; tiles, current_turn and move_count are unchanged.
- After 2 moves, undo rise -> tiles returns to the 1-move board, current_turn = 1, move_count = 1. A second undo gives an empty board. A third undo pulses move_reject.
- Undo rise and switch[5] rise in the same cycle -> undo executes and switch 5 is discarded. Full-board draw sequence -> winner = 00, game_over = 1, move_count = 9.
- Reset asserted during S_MOVE -> all outputs are 0 asynchronously, before the next clk edge.
